// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative multiply/divide sequencer owning the HI/LO pair.
// MULT/MULTU use a shift-add over a 64-bit accumulator, DIV/DIVU use a
// restoring divider. Both run one bit per cycle. MTHI/MTLO complete in
// IDLE with zero latency. stall holds the pipeline while an op is in flight.
module ex_muldiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_hilo,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_MUL = 2'd1,
        RUN_DIV = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [63:0] acc_q, acc_d;        // multiply: {partial product, remaining multiplier}
    logic [31:0] opa_q, opa_d;        // multiplicand magnitude or divisor magnitude
    logic [31:0] quo_q, quo_d;        // dividend shifting out / quotient shifting in
    logic [31:0] rem_q, rem_d;        // divide partial remainder
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] mul_res;
    logic [32:0] div_shift;
    logic        div_qbit;
    logic [31:0] div_rem_step;
    logic [31:0] div_quo_step;
    logic        op_valid;
    logic        last_iter;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign op_valid  = (op >= OP_MULT) && (op <= OP_MTLO);
    assign stall     = busy & ((start & op_valid) | rd_hilo);
    assign last_iter = (cnt_q == CNT_LAST);

    // Operand magnitudes at accept time; unsigned ops pass operands through.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = (signed_op && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
        b_mag     = (signed_op && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
    end

    // One shift-add step and one restoring-divide step, used by the RUN states.
    always_comb begin
        mul_sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
        mul_step     = {mul_sum, acc_q[31:1]};
        mul_res      = neg_res_q ? (~mul_step + 64'd1) : mul_step;
        div_shift    = {rem_q, quo_q[31]};
        div_qbit     = (div_shift >= {1'b0, opa_q});
        div_rem_step = div_qbit ? (div_shift[31:0] - opa_q) : div_shift[31:0];
        div_quo_step = {quo_q[30:0], div_qbit};
    end

    // Next-state logic: accept in IDLE, iterate in RUN_*, final write or flush abort.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        acc_d     = acc_q;
        opa_d     = opa_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {32'd0, b_mag};
                            opa_d     = a_mag;
                            neg_res_d = signed_op & (rs_val[31] ^ rt_val[31]);
                            neg_rem_d = 1'b0;
                            cnt_d     = 6'd0;
                            state_d   = RUN_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            cnt_d     = 6'd0;
                            rem_d     = 32'd0;
                            state_d   = RUN_DIV;
                            div0_d    = (rt_val == 32'd0);
                            // Divide by zero keeps the raw dividend for HI.
                            quo_d     = (rt_val == 32'd0) ? rs_val : a_mag;
                            opa_d     = b_mag;
                            neg_res_d = signed_op & (rs_val[31] ^ rt_val[31]);
                            neg_rem_d = signed_op & rs_val[31];
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN_MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    acc_d = mul_step;
                    if (last_iter) begin
                        {hi_d, lo_d} = mul_res;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            RUN_DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div0_q) begin
                    hi_d    = quo_q;
                    lo_d    = 32'hFFFF_FFFF;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    rem_d = div_rem_step;
                    quo_d = div_quo_step;
                    if (last_iter) begin
                        lo_d    = neg_res_q ? (~div_quo_step + 32'd1) : div_quo_step;
                        hi_d    = neg_rem_q ? (~div_rem_step + 32'd1) : div_rem_step;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            acc_q     <= 64'd0;
            opa_q     <= 32'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Multi-cycle multiply/divide sequencer beside the EX-stage ALU. It owns the HI/LO register pair and executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles. It services MTHI/MTLO writes and MFHI/MFLO reads. It raises a stall to the pipeline whenever an instruction needs the unit while an operation is in flight.

## Interface
Parameters:
- `ITER`, 32: iterations per mult/div operation. Equals the operand width and is fixed at 32.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  EX stage issues a muldiv-class op this cycle
- `op`  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others treated as none
- `rs_val`  in  32  forwarded rs operand (multiplicand, dividend, or MTHI/MTLO data)
- `rt_val`  in  32  forwarded rt operand (multiplier or divisor)
- `rd_hilo`  in  1  MFHI/MFLO in EX this cycle
- `flush`  in  1  abort the in-flight op (exception/redirect)
- `stall`  out  1  combinational; pipeline must hold IF/ID/EX
- `busy`  out  1  registered; an op is in flight
- `done`  out  1  registered one-cycle pulse after a mult/div result is written
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, RUN_MUL, RUN_DIV. `busy` = (state != IDLE).
- `stall` = `busy` & (`start` & `op`!=none | `rd_hilo`). `stall` is never asserted in IDLE.
- Accept rule: in IDLE, with `start`, a valid op, and `flush` low, the op is accepted at that edge (E0).
- MULT/DIV accept:
  - Latch operand magnitudes (two's-complement abs for signed ops) and the result signs.
  - Clear the 6-bit iteration counter.
  - Enter RUN_MUL or RUN_DIV.
- MULTU/DIVU accept: operands are used as-is and the sign fix is disabled.
- RUN_MUL:
  - Shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
  - On iteration 32 (edge E32), {hi,lo} ← product, negated if the sign fix is enabled and the operand signs differ.
- RUN_DIV:
  - Restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
  - At E32, lo ← quotient, negated if the operand signs differ.
  - At E32, hi ← remainder, negated if the dividend is negative.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (rt_val=0, DIV or DIVU):
  - Enter RUN_DIV.
  - At E1, hi ← original rs_val and lo ← 0xFFFFFFFF.
  - Return to IDLE with `done` pulsed.
- MTHI/MTLO accepted in IDLE: hi (or lo) ← rs_val at E0. State stays IDLE and `done` is not pulsed.
- Final write:
  - At the final-write edge, state → IDLE and `done`=1 for exactly the next cycle.
  - A stalled op is accepted at the first edge after `busy` falls (the pipeline re-presents it).
- `flush`:
  - In RUN_*, the next edge returns to IDLE with hi/lo unchanged and no `done` pulse.
  - In IDLE, `flush` blocks acceptance of a same-cycle `start`.
  - If `flush` is high on the final-write edge, the write is suppressed.
- Reset: any time, including mid-operation, gives state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, and all internal operand registers = 0.

## Timing
- Latency from E0:
  - MULT/MULTU/DIV/DIVU: result visible on hi/lo after E32. `busy` is high for 32 cycles and `done` is high in the cycle after E32.
  - Divide by zero: 1 cycle.
  - MTHI/MTLO: 0 cycles of busy, visible after E0.
- MFHI/MFLO in IDLE reads hi/lo combinationally in the same cycle. No internal bypass of a same-cycle MTHI/MTLO.
- `stall` must fall in the same cycle `busy` falls (combinational path from state).
- No new op is accepted while `busy`=1. Back-to-back ops are separated by at least one IDLE cycle, the cycle where `done`=1.
- `start` with op=none, or an unused code, does nothing and causes no stall.

## Test plan
- MULT rs=0xFFFFFFFD (−3), rt=5:
  - Expect busy for 32 cycles and done one cycle after E32.
  - Expect hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MULTU with the same operands gives hi=0x00000004, lo=0xFFFFFFF1.
- DIV rs=7, rt=0xFFFFFFFE (−2): expect lo=0xFFFFFFFD, hi=0x00000001. DIVU 100/7: expect lo=14, hi=2.
- Boundary cases:
  - DIVU 0x1234/0: expect after 1 cycle hi=0x1234, lo=0xFFFFFFFF, and done pulse.
  - DIV 0x80000000/0xFFFFFFFF: expect lo=0x80000000, hi=0.
- Stall and reads during a MULT:
  - MFHI (rd_hilo=1) at cycle 10 of the MULT: expect stall=1 until busy falls, then hi read equals the new product.
  - MTLO issued while busy: expect stall, and lo equals the MTLO data only after acceptance.
- Flush and reset mid-operation:
  - Preload hi=0xAAAA, lo=0x5555 via MTHI/MTLO.
  - Start MULT, assert flush at cycle 20: expect IDLE next cycle, no done, hi/lo unchanged.
  - Repeat with rst low at cycle 15: expect all outputs 0 immediately (asynchronous).
- Same-cycle flush and start in IDLE: expect no acceptance, busy stays 0, hi/lo unchanged.
